// File: rtl/mdr_mem_port.sv
// Memory data register with a legacy bus/memory load path and a sized, lane-aligned
// load/store port (req/ack handshake, sign/zero extension, byte enables, ack timeout).
module mdr_mem_port #(
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int NL      = DATA_W / 8,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              MDRin,
  input  logic              read,
  input  logic              mem_rd_start,
  input  logic              mem_wr_start,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [NL-1:0]     mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] MDRout,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              align_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mdr_q, mdr_d, wdata_q, wdata_d;
  logic              req_q, req_d, we_q, we_d, done_q, done_d;
  logic              terr_q, terr_d, aerr_q, aerr_d;
  logic [NL-1:0]     be_q, be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic              start, aligned, fill;
  logic [NL-1:0]     be_byte, be_half;
  logic [DATA_W-1:0] rep_byte, rep_half, shifted, rd_val;

  // Lane helpers: write enables/data use the request being started, read extraction
  // uses the size/offset latched when the read began.
  always_comb begin
    start   = mem_rd_start | mem_wr_start;
    aligned = size[1] ? (byte_off == '0) : (size[0] ? ~byte_off[0] : 1'b1);

    be_byte    = '0;
    be_byte[0] = 1'b1;
    be_byte    = be_byte << byte_off;
    be_half      = '0;
    be_half[1:0] = 2'b11;
    be_half      = be_half << byte_off;

    for (int i = 0; i < NL; i++) begin
      rep_byte[8*i +: 8] = mdr_q[7:0];
      rep_half[8*i +: 8] = mdr_q[8*(i%2) +: 8];
    end

    shifted = Mdatain >> {off_q, 3'b000};
    rd_val  = shifted;
    fill    = 1'b0;
    if (size_q[1]) begin
      rd_val = Mdatain;
    end else if (size_q[0]) begin
      fill = sext_q & shifted[15];
      for (int i = 16; i < DATA_W; i++) rd_val[i] = fill;
    end else begin
      fill = sext_q & shifted[7];
      for (int i = 8; i < DATA_W; i++) rd_val[i] = fill;
    end
  end

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    aerr_d  = aerr_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          terr_d = 1'b0;
          aerr_d = 1'b0;
          size_d = size;
          sext_d = sign_ext;
          off_d  = byte_off;
          cnt_d  = '0;
          if (!aligned) begin
            aerr_d = 1'b1;
            done_d = 1'b1;
          end else if (mem_rd_start) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            be_d    = '0;
            state_d = RD_WAIT;
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            be_d    = size[1] ? '1 : (size[0] ? be_half : be_byte);
            wdata_d = size[1] ? mdr_q : (size[0] ? rep_half : rep_byte);
            state_d = WR_WAIT;
          end
        end else if (MDRin) begin
          mdr_d = read ? Mdatain : BusMuxOut;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // An ack on the last permitted cycle wins over the timeout.
        if (mem_ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (!mem_ack)                 terr_d = 1'b1;
          else if (state_q == RD_WAIT)  mdr_d  = rd_val;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      aerr_q  <= 1'b0;
      cnt_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      aerr_q  <= aerr_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign MDRout      = mdr_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign align_err   = aerr_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed bench for mdr_mem_port: transaction-level reference model compared every
// cycle, plus literal expectations for the headline scenarios.
module tb_mdr_mem_port;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        MDRin = 1'b0, read = 1'b0;
  logic        mem_rd_start = 1'b0, mem_wr_start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [1:0]  byte_off = 2'b00;
  logic [31:0] BusMuxOut = '0, Mdatain = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, busy, done, timeout_err, align_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, MDRout;

  mdr_mem_port #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .MDRin(MDRin), .read(read),
    .mem_rd_start(mem_rd_start), .mem_wr_start(mem_wr_start),
    .size(size), .sign_ext(sign_ext), .byte_off(byte_off),
    .BusMuxOut(BusMuxOut), .Mdatain(Mdatain), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .MDRout(MDRout), .busy(busy), .done(done),
    .timeout_err(timeout_err), .align_err(align_err)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one operation in flight, described by what it asked for and how
  // many request cycles it has used.
  logic [31:0] m_mdr, m_wdata;
  logic        m_req, m_we, m_done, m_terr, m_aerr, m_sx;
  logic [3:0]  m_be;
  logic [1:0]  m_sz, m_off;
  int          m_wait;

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                          input logic [1:0] off, input logic sx);
    logic [31:0] s, mask, v;
    if (sz[1]) return d;
    s    = d >> (8 * off);
    mask = sz[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    v    = s & mask;
    if (sx && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
    return v;
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
    if (sz[1]) return off == 2'd0;
    if (sz[0]) return off % 2 == 0;
    return 1'b1;
  endfunction

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_mdr <= '0; m_wdata <= '0; m_req <= 1'b0; m_we <= 1'b0; m_done <= 1'b0;
      m_terr <= 1'b0; m_aerr <= 1'b0; m_be <= '0; m_wait <= 0;
      m_sz <= '0; m_off <= '0; m_sx <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_req) begin
        if (mem_ack) begin
          m_req <= 1'b0; m_done <= 1'b1;
          if (!m_we) m_mdr <= extract(Mdatain, m_sz, m_off, m_sx);
        end else if (m_wait + 1 == TIMEOUT) begin
          m_req <= 1'b0; m_done <= 1'b1; m_terr <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (mem_rd_start || mem_wr_start) begin
        m_terr <= 1'b0; m_sz <= size; m_off <= byte_off; m_sx <= sign_ext; m_wait <= 0;
        if (!is_aligned(size, byte_off)) begin
          m_aerr <= 1'b1; m_done <= 1'b1;
        end else begin
          m_aerr <= 1'b0; m_req <= 1'b1; m_we <= !mem_rd_start;
          m_be <= size[1] ? 4'hF : (size[0] ? (4'b0011 << byte_off) : (4'b0001 << byte_off));
          m_wdata <= size[1] ? m_mdr :
                     (size[0] ? m_mdr[15:0] * 32'h0001_0001 : m_mdr[7:0] * 32'h0101_0101);
        end
      end else if (MDRin) begin
        m_mdr <= read ? Mdatain : BusMuxOut;
      end
    end
  end

  always @(negedge clock) begin
    if (clear && cmp_en) begin
      check("MDRout", MDRout, m_mdr);
      check("mem_req", 32'(mem_req), 32'(m_req));
      check("busy", 32'(busy), 32'(m_req));
      check("done", 32'(done), 32'(m_done));
      check("timeout_err", 32'(timeout_err), 32'(m_terr));
      check("align_err", 32'(align_err), 32'(m_aerr));
      if (m_req) begin
        check("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) begin
          check("mem_be", 32'(mem_be), 32'(m_be));
          check("mem_wdata", mem_wdata, m_wdata);
        end
      end
    end
  end

  task automatic legacy(input logic rd, input logic [31:0] md, input logic [31:0] bm);
    MDRin = 1'b1; read = rd; Mdatain = md; BusMuxOut = bm;
    @(negedge clock);
    MDRin = 1'b0;
  endtask

  task automatic start_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [1:0] off, input logic sx);
    mem_rd_start = rd; mem_wr_start = wr; size = sz; byte_off = off; sign_ext = sx;
    @(negedge clock);
    mem_rd_start = 1'b0; mem_wr_start = 1'b0;
  endtask

  // Called one cycle after the start edge; the ack is sampled k edges after start.
  task automatic ack_after(input int k);
    repeat (k - 1) @(negedge clock);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clock);
    check("rst MDRout", MDRout, 32'h0);
    check("rst mem_req", 32'(mem_req), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst errs", 32'({timeout_err, align_err}), 32'h0);
    clear  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clock);

    // Legacy loads from memory side and bus side.
    legacy(1'b1, 32'hAAAA_AAAA, 32'h0);
    check("legacy rd", MDRout, 32'hAAAA_AAAA);
    legacy(1'b0, 32'h0, 32'hFFFF_FFFF);
    check("legacy bus", MDRout, 32'hFFFF_FFFF);

    // Byte read at offset 2, signed then unsigned.
    Mdatain = 32'h12F4_5678;
    start_op(1'b1, 1'b0, 2'b00, 2'd2, 1'b1);
    ack_after(3);
    check("sbyte MDRout", MDRout, 32'hFFFF_FFF4);
    check("sbyte done", 32'(done), 32'h1);
    @(negedge clock);
    check("sbyte done pulse", 32'(done), 32'h0);
    start_op(1'b1, 1'b0, 2'b00, 2'd2, 1'b0);
    ack_after(3);
    check("ubyte MDRout", MDRout, 32'h0000_00F4);

    // Half write at offset 2; an MDRin pulse while busy must be ignored.
    legacy(1'b0, 32'h0, 32'h0000_BEEF);
    start_op(1'b0, 1'b1, 2'b01, 2'd2, 1'b0);
    check("hw mem_we", 32'(mem_we), 32'h1);
    check("hw mem_be", 32'(mem_be), 32'hC);
    check("hw wdata", mem_wdata, 32'hBEEF_BEEF);
    MDRin = 1'b1; read = 1'b0; BusMuxOut = 32'h1234_5678;
    @(negedge clock);
    MDRin = 1'b0;
    check("hw wdata held", mem_wdata, 32'hBEEF_BEEF);
    ack_after(2);
    check("hw req drop", 32'(mem_req), 32'h0);
    check("hw MDR kept", MDRout, 32'h0000_BEEF);

    // Timeout with no ack.
    legacy(1'b0, 32'h0, 32'h1357_9BDF);
    start_op(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
    n = 0;
    while (mem_req && n < TIMEOUT + 5) begin
      n++;
      @(negedge clock);
    end
    check("tmo req cycles", 32'(n), 32'(TIMEOUT));
    check("tmo err", 32'(timeout_err), 32'h1);
    check("tmo done", 32'(done), 32'h1);
    check("tmo MDR kept", MDRout, 32'h1357_9BDF);
    @(negedge clock);
    check("tmo err sticky", 32'(timeout_err), 32'h1);

    // Ack on the last permitted cycle is a success.
    Mdatain = 32'h89AB_CDEF;
    start_op(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
    ack_after(TIMEOUT);
    check("late ack done", 32'(done), 32'h1);
    check("late ack no err", 32'(timeout_err), 32'h0);
    check("late ack MDR", MDRout, 32'h89AB_CDEF);

    // Misaligned half, then simultaneous starts.
    start_op(1'b1, 1'b0, 2'b01, 2'd1, 1'b0);
    check("mis req", 32'(mem_req), 32'h0);
    check("mis align_err", 32'(align_err), 32'h1);
    check("mis done", 32'(done), 32'h1);
    @(negedge clock);
    check("mis req later", 32'(mem_req), 32'h0);
    check("mis err sticky", 32'(align_err), 32'h1);
    Mdatain = 32'hCAFE_F00D;
    start_op(1'b1, 1'b1, 2'b10, 2'd0, 1'b0);
    check("both is read", 32'(mem_we), 32'h0);
    ack_after(1);
    check("both MDR", MDRout, 32'hCAFE_F00D);
    check("both err clr", 32'(align_err), 32'h0);

    // Stray ack while idle.
    @(negedge clock);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check("stray ack", 32'(done), 32'h0);

    // Reset in the middle of a read.
    start_op(1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("midrst MDRout", MDRout, 32'h0);
    check("midrst req", 32'(mem_req), 32'h0);
    check("midrst busy", 32'(busy), 32'h0);
    check("midrst done", 32'(done), 32'h0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    check("postrst done", 32'(done), 32'h0);
    check("postrst busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
